// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the up/down counter primitive.
//   DIR_UP / DIR_DOWN : encodings of the dir input.
//   eff_mod()         : effective modulus M (MODULUS, or 2^WIDTH when 0).
//                       The caller truncates the result to WIDTH+1 bits,
//                       which is always wide enough to hold 2^WIDTH.
// -----------------------------------------------------------------------------
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic longint unsigned eff_mod(input int width, input int modulus);
    if (modulus == 0)
      return 64'd1 << width;
    else
      return longint'(modulus);
  endfunction

endpackage : counter_pkg

// File: rtl/updown_counter_if.sv
// -----------------------------------------------------------------------------
// updown_counter_if
// Control and status bundle of the up/down counter.
//   master : drives clear, load, preset, en, dir, step; observes status.
//   slave  : the counter itself; drives out, wrap, err, at_max, at_min.
// clk and reset are kept as plain module ports, outside this bundle.
// -----------------------------------------------------------------------------
interface updown_counter_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);

  logic              clear;
  logic              load;
  logic [WIDTH-1:0]  preset;
  logic              en;
  logic              dir;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  out;
  logic              wrap;
  logic              err;
  logic              at_max;
  logic              at_min;

  modport master (
    output clear, load, preset, en, dir, step,
    input  out, wrap, err, at_max, at_min
  );

  modport slave (
    input  clear, load, preset, en, dir, step,
    output out, wrap, err, at_max, at_min
  );

endinterface : updown_counter_if

// File: rtl/counter_next.sv
// -----------------------------------------------------------------------------
// counter_next
// Combinational next-count calculation for one enabled counting cycle.
//   cur      in  WIDTH   current count (0..M-1)
//   dir      in  1       1 = up, 0 = down
//   step     in  STEP_W  increment magnitude
//   mode     in  1       0 = wrap, 1 = saturate
//   next_val out WIDTH   count after this step
//   wrap_evt out 1       range end crossed (wrapped or clamped)
//   step_err out 1       step >= M; next_val then equals cur
// A step of 0 also leaves the count unchanged and raises no event.
// -----------------------------------------------------------------------------
module counter_next
  import counter_pkg::*;
#(
  parameter int             WIDTH  = 8,
  parameter int             STEP_W = 4,
  parameter logic [WIDTH:0] M      = {1'b1, {WIDTH{1'b0}}}
) (
  input  logic [WIDTH-1:0]  cur,
  input  logic              dir,
  input  logic [STEP_W-1:0] step,
  input  logic              mode,
  output logic [WIDTH-1:0]  next_val,
  output logic              wrap_evt,
  output logic              step_err
);

  // Internal arithmetic width: covers both operands plus a carry bit so
  // that out+step and out+M never overflow.
  localparam int CW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 2;

  logic [CW-1:0] cur_x;
  logic [CW-1:0] stp_x;
  logic [CW-1:0] mod_x;
  logic [CW-1:0] sum_x;
  logic [CW-1:0] res_x;

  assign cur_x = CW'(cur);
  assign stp_x = CW'(step);
  assign mod_x = CW'(M);
  assign sum_x = cur_x + stp_x;

  always_comb begin
    res_x    = cur_x;
    wrap_evt = 1'b0;
    step_err = (stp_x >= mod_x);

    if (!step_err && (stp_x != '0)) begin
      if (dir == DIR_UP) begin
        if (sum_x >= mod_x) begin
          wrap_evt = 1'b1;
          res_x    = mode ? (mod_x - CW'(1)) : (sum_x - mod_x);
        end else begin
          res_x = sum_x;
        end
      end else begin
        if (stp_x > cur_x) begin
          wrap_evt = 1'b1;
          res_x    = mode ? '0 : (cur_x + mod_x - stp_x);
        end else begin
          res_x = cur_x - stp_x;
        end
      end
    end
  end

  // Result is always below M, so the upper bits are zero by construction.
  assign next_val = res_x[WIDTH-1:0];

endmodule : counter_next

// File: rtl/updown_counter.sv
// -----------------------------------------------------------------------------
// updown_counter
// General counter primitive: synchronous clear/load, up/down counting with a
// programmable step, arbitrary modulus, wrap or saturate at the range ends.
//   clk    in  clock, rising edge
//   reset  in  asynchronous, active-high; clears out, wrap, err
//   bus    slave side of updown_counter_if:
//          clear, load, preset, en, dir, step  -> controls (clear > load > en)
//          out, wrap, err                      <- registered status
//          at_max, at_min                      <- decoded from out
// MODULUS must be 0 (meaning 2^WIDTH) or in 2..2^WIDTH.
// -----------------------------------------------------------------------------
module updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 0,
  parameter int SATURATE = 0,
  parameter int STEP_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  updown_counter_if.slave  bus
);

  localparam logic [WIDTH:0]   M       = (WIDTH+1)'(eff_mod(WIDTH, MODULUS));
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(M - 1'b1);
  localparam logic             MODE    = (SATURATE != 0);

  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] step_val;
  logic             step_wrap;
  logic             step_err;

  counter_next #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W),
    .M      (M)
  ) u_next (
    .cur      (out_q),
    .dir      (bus.dir),
    .step     (bus.step),
    .mode     (MODE),
    .next_val (step_val),
    .wrap_evt (step_wrap),
    .step_err (step_err)
  );

  // Priority mux; flags default to 0 so they are single-cycle pulses.
  always_comb begin
    out_d  = out_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (bus.clear) begin
      out_d = '0;
    end else if (bus.load) begin
      if ({1'b0, bus.preset} >= M) begin
        out_d = MAX_VAL;
        err_d = 1'b1;
      end else begin
        out_d = bus.preset;
      end
    end else if (bus.en) begin
      if (step_err) begin
        err_d = 1'b1;
      end else begin
        out_d  = step_val;
        wrap_d = step_wrap;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign bus.out    = out_q;
  assign bus.wrap   = wrap_q;
  assign bus.err    = err_q;
  assign bus.at_max = (out_q == MAX_VAL);
  assign bus.at_min = (out_q == '0);

endmodule : updown_counter

// File: tb/tb_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_updown_counter
// Three counter instances sharing clk and reset:
//   a : WIDTH=8, MODULUS=10, wrap
//   b : WIDTH=8, MODULUS=10, saturate
//   c : WIDTH=8, MODULUS=0 (256), wrap
// Directed vectors with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_updown_counter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  updown_counter_if #(.WIDTH(8), .STEP_W(4)) ifa ();
  updown_counter_if #(.WIDTH(8), .STEP_W(4)) ifb ();
  updown_counter_if #(.WIDTH(8), .STEP_W(4)) ifc ();

  updown_counter #(.WIDTH(8), .MODULUS(10), .SATURATE(0), .STEP_W(4)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  updown_counter #(.WIDTH(8), .MODULUS(10), .SATURATE(1), .STEP_W(4)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));
  updown_counter #(.WIDTH(8), .MODULUS(0), .SATURATE(0), .STEP_W(4)) dut_c (
    .clk(clk), .reset(reset), .bus(ifc));

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ifa.clear = 0; ifa.load = 0; ifa.preset = 0; ifa.en = 0; ifa.dir = 1; ifa.step = 0;
    ifb.clear = 0; ifb.load = 0; ifb.preset = 0; ifb.en = 0; ifb.dir = 1; ifb.step = 0;
    ifc.clear = 0; ifc.load = 0; ifc.preset = 0; ifc.en = 0; ifc.dir = 1; ifc.step = 0;

    // ---- reset state ----
    tick(); tick();
    chk_val("rst_out",    ifa.out, 0);
    chk_val("rst_wrap",   ifa.wrap, 0);
    chk_val("rst_err",    ifa.err, 0);
    chk_val("rst_at_min", ifa.at_min, 1);
    reset = 0;

    // ---- A: up count step 1, mod 10 ----
    ifa.en = 1; ifa.dir = 1; ifa.step = 1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk_val($sformatf("a_up%0d_out", i),    ifa.out, i % 10);
      chk_val($sformatf("a_up%0d_wrap", i),   ifa.wrap, (i % 10) == 0);
      chk_val($sformatf("a_up%0d_at_max", i), ifa.at_max, (i % 10) == 9);
    end

    // ---- A: load 7 then down step 3 ----
    ifa.en = 0; ifa.load = 1; ifa.preset = 7;
    tick();
    chk_val("a_load7_out", ifa.out, 7);
    chk_val("a_load7_err", ifa.err, 0);
    ifa.load = 0; ifa.en = 1; ifa.dir = 0; ifa.step = 3;
    tick(); chk_val("a_dn1_out", ifa.out, 4); chk_val("a_dn1_wrap", ifa.wrap, 0);
    tick(); chk_val("a_dn2_out", ifa.out, 1); chk_val("a_dn2_wrap", ifa.wrap, 0);
    tick(); chk_val("a_dn3_out", ifa.out, 8); chk_val("a_dn3_wrap", ifa.wrap, 1);

    // ---- A: illegal load ----
    ifa.en = 0; ifa.load = 1; ifa.preset = 12;
    tick(); chk_val("a_load12_out", ifa.out, 9); chk_val("a_load12_err", ifa.err, 1);
    ifa.load = 0;
    tick(); chk_val("a_idle_out", ifa.out, 9); chk_val("a_idle_err", ifa.err, 0);
    chk_val("a_idle_wrap", ifa.wrap, 0);

    // ---- A: priority ----
    ifa.clear = 1; ifa.load = 1; ifa.preset = 5; ifa.en = 1; ifa.dir = 1; ifa.step = 1;
    tick(); chk_val("a_clr_prio_out", ifa.out, 0);
    ifa.clear = 0;
    tick(); chk_val("a_load_prio_out", ifa.out, 5);
    ifa.load = 0;

    // ---- A: illegal steps ----
    ifa.step = 12;
    tick(); chk_val("a_step12_out", ifa.out, 5); chk_val("a_step12_err", ifa.err, 1);
    ifa.step = 10;
    tick(); chk_val("a_step10_out", ifa.out, 5); chk_val("a_step10_err", ifa.err, 1);
    ifa.step = 1;
    tick(); chk_val("a_step1_out", ifa.out, 6); chk_val("a_step1_err", ifa.err, 0);

    // ---- A: async reset mid-count ----
    ifa.load = 1; ifa.preset = 9;
    tick(); chk_val("a_pre_rst_load", ifa.out, 9);
    ifa.load = 0;
    tick(); chk_val("a_pre_rst_out", ifa.out, 0); chk_val("a_pre_rst_wrap", ifa.wrap, 1);
    ifa.load = 1; ifa.preset = 4;
    tick(); chk_val("a_pre_rst_out2", ifa.out, 4);
    ifa.load = 0;
    #2 reset = 1;
    #1;
    chk_val("a_async_rst_out",  ifa.out, 0);
    chk_val("a_async_rst_wrap", ifa.wrap, 0);
    chk_val("a_async_rst_err",  ifa.err, 0);
    tick(); chk_val("a_rst_hold_out", ifa.out, 0);
    #2 reset = 0;
    tick(); chk_val("a_resume_out", ifa.out, 1);
    ifa.en = 0;

    // ---- B: saturate, mod 10 ----
    ifb.load = 1; ifb.preset = 8;
    tick(); chk_val("b_load8_out", ifb.out, 8);
    ifb.load = 0; ifb.en = 1; ifb.dir = 1; ifb.step = 3;
    tick(); chk_val("b_sat_up1_out", ifb.out, 9); chk_val("b_sat_up1_wrap", ifb.wrap, 1);
    tick(); chk_val("b_sat_up2_out", ifb.out, 9); chk_val("b_sat_up2_wrap", ifb.wrap, 1);
    ifb.en = 0; ifb.load = 1; ifb.preset = 6;
    tick(); chk_val("b_load6_out", ifb.out, 6);
    ifb.load = 0; ifb.en = 1;
    tick(); chk_val("b_exact_max_out", ifb.out, 9); chk_val("b_exact_max_wrap", ifb.wrap, 0);
    ifb.en = 0; ifb.load = 1; ifb.preset = 1;
    tick();
    ifb.load = 0; ifb.en = 1; ifb.dir = 0; ifb.step = 4;
    tick(); chk_val("b_sat_dn1_out", ifb.out, 0); chk_val("b_sat_dn1_wrap", ifb.wrap, 1);
    tick(); chk_val("b_sat_dn2_out", ifb.out, 0); chk_val("b_sat_dn2_wrap", ifb.wrap, 1);
    ifb.en = 0; ifb.load = 1; ifb.preset = 1;
    tick();
    ifb.load = 0; ifb.en = 1; ifb.step = 1;
    tick(); chk_val("b_exact_min_out", ifb.out, 0); chk_val("b_exact_min_wrap", ifb.wrap, 0);
    ifb.en = 0; ifb.load = 1; ifb.preset = 12;
    tick(); chk_val("b_load12_out", ifb.out, 9); chk_val("b_load12_err", ifb.err, 1);
    ifb.load = 0;

    // ---- C: full range 256 ----
    ifc.load = 1; ifc.preset = 8'hFE;
    tick(); chk_val("c_loadfe_out", ifc.out, 8'hFE);
    ifc.load = 0; ifc.en = 1; ifc.dir = 1; ifc.step = 3;
    tick(); chk_val("c_ovf_out", ifc.out, 8'h01); chk_val("c_ovf_wrap", ifc.wrap, 1);
    ifc.step = 0;
    tick(); chk_val("c_step0_out", ifc.out, 8'h01); chk_val("c_step0_wrap", ifc.wrap, 0);
    chk_val("c_step0_err", ifc.err, 0);
    ifc.dir = 0; ifc.step = 2;
    tick(); chk_val("c_unf_out", ifc.out, 8'hFF); chk_val("c_unf_wrap", ifc.wrap, 1);
    chk_val("c_unf_at_max", ifc.at_max, 1);
    ifc.step = 15;
    tick(); chk_val("c_dn15_out", ifc.out, 8'hF0); chk_val("c_dn15_err", ifc.err, 0);
    ifc.en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_updown_counter
